math_peak_search: RTL

Framed peak detector that consumes the magnitude stream produced by the complex-magnitude stage. It sits directly downstream of that stage.
- Each frame is FRAME_LEN valid samples.
- Per frame it reports the largest magnitude, that sample's index, the frame sum (for a noise-floor mean) and a threshold decision.
- The results feed the detection/ranging logic.

---
 rtl/math_peak_search.sv | 126 ++++++++++++
 1 files changed

// File: rtl/math_peak_search.sv
// Framed peak detector: per FRAME_LEN valid samples reports the maximum magnitude,
// its index, the frame sum and a threshold decision.
module math_peak_search #(
   parameter int unsigned DIN_WIDTH = 34,
   parameter int unsigned FRAME_LEN = 64,
   parameter int unsigned IDX_WIDTH = 6
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           start,
   input  logic [DIN_WIDTH-1:0]           thresh,
   input  logic                           din_valid,
   input  logic [DIN_WIDTH-1:0]           din,
   output logic                           busy,
   output logic                           dout_valid,
   output logic [DIN_WIDTH-1:0]           peak_val,
   output logic [IDX_WIDTH-1:0]           peak_idx,
   output logic                           peak_found,
   output logic [DIN_WIDTH+IDX_WIDTH-1:0] sum
);

   localparam int unsigned ACC_WIDTH = DIN_WIDTH + IDX_WIDTH;
   localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(FRAME_LEN - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t                 state_q;
   state_t                 state_d;
   logic [IDX_WIDTH-1:0]   cnt;
   logic [ACC_WIDTH-1:0]   acc;
   logic [DIN_WIDTH-1:0]   run_peak;
   logic [IDX_WIDTH-1:0]   run_idx;
   logic [DIN_WIDTH-1:0]   thr_q;

   logic                   arm_c;
   logic                   take_c;
   logic                   last_c;
   logic [ACC_WIDTH-1:0]   acc_d;
   logic [DIN_WIDTH-1:0]   peak_d;
   logic [IDX_WIDTH-1:0]   idx_d;

   // Next state and the running values including the current sample
   always_comb begin
      state_d = state_q;
      arm_c   = 1'b0;
      take_c  = 1'b0;
      last_c  = 1'b0;
      acc_d   = acc + ACC_WIDTH'(din);
      peak_d  = run_peak;
      idx_d   = run_idx;
      // Strict compare keeps the earliest index on ties
      if (din > run_peak) begin
         peak_d = din;
         idx_d  = cnt;
      end
      case (state_q)
         IDLE: begin
            if (start) begin
               arm_c   = 1'b1;
               state_d = RUN;
            end
         end
         RUN: begin
            if (din_valid) begin
               take_c = 1'b1;
               if (cnt == LAST_IDX) begin
                  last_c  = 1'b1;
                  state_d = DONE;
               end
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= IDLE;
      else      state_q <= state_d;
   end

   // Frame accumulators and result registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt        <= '0;
         acc        <= '0;
         run_peak   <= '0;
         run_idx    <= '0;
         thr_q      <= '0;
         busy       <= 1'b0;
         dout_valid <= 1'b0;
         peak_val   <= '0;
         peak_idx   <= '0;
         peak_found <= 1'b0;
         sum        <= '0;
      end else begin
         dout_valid <= last_c;
         if (arm_c) begin
            cnt      <= '0;
            acc      <= '0;
            run_peak <= '0;
            run_idx  <= '0;
            thr_q    <= thresh;
            busy     <= 1'b1;
         end
         if (take_c) begin
            cnt      <= cnt + IDX_WIDTH'(1);
            acc      <= acc_d;
            run_peak <= peak_d;
            run_idx  <= idx_d;
         end
         if (last_c) begin
            busy       <= 1'b0;
            peak_val   <= peak_d;
            peak_idx   <= idx_d;
            sum        <= acc_d;
            peak_found <= (peak_d >= thr_q);
         end
      end
   end

endmodule
